// File: rtl/estirador_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encoding and default sizing.
package estirador_pkg;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    ACTIVO = 2'd1,
    GUARDA = 2'd2
  } estado_t;

  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned GUARDA_DEF = 2;
  localparam int unsigned GCNT_W     = 4;

endpackage

// File: rtl/estirador_pulsos_contador.sv
// Loadable down-counter with zero and last-count flags; load wins over decrement
// and the count saturates at zero.
module contador_descendente #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         carga_i,
  input  logic [W-1:0] valor_i,
  input  logic         dec_i,
  output logic         cero_o,
  output logic         ultimo_o
);

  logic [W-1:0] cuenta_q, cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (carga_i) begin
      cuenta_d = valor_i;
    end else if (dec_i && (cuenta_q != '0)) begin
      cuenta_d = cuenta_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  assign cero_o   = (cuenta_q == '0);
  assign ultimo_o = (cuenta_q == W'(1));

endmodule

// File: rtl/estirador_pulsos.sv
// Pulse stretcher: a trigger yields a max(iAncho,1)-cycle high pulse followed by a forced-low
// guard time. Define ESTIRADOR_REDISPARO_EN to let triggers during the pulse restart it.
module estirador_pulsos
  import estirador_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned GUARDA = GUARDA_DEF
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iDisparo,
  input  logic [CNT_W-1:0] iAncho,
  output logic             oSenal,
  output logic             oOcupado,
  output logic             oPerdido
);

  localparam logic [GCNT_W-1:0] GUARDA_CARGA = GCNT_W'(GUARDA);

  estado_t           estado_q, estado_d;
  logic [GCNT_W-1:0] guarda_q, guarda_d;
  logic              senal_q, senal_d;
  logic              ocupado_q, ocupado_d;
  logic              perdido_q, perdido_d;
  logic              carga, dec, cero, ultimo;
  logic [CNT_W-1:0]  ancho_ef;

  assign ancho_ef = (iAncho == '0) ? CNT_W'(1) : iAncho;

  contador_descendente #(
    .W (CNT_W)
  ) u_contador (
    .clk_i    (iClk),
    .rst_i    (iReset),
    .carga_i  (carga),
    .valor_i  (ancho_ef),
    .dec_i    (dec),
    .cero_o   (cero),
    .ultimo_o (ultimo)
  );

  always_comb begin
    estado_d  = estado_q;
    guarda_d  = guarda_q;
    carga     = 1'b0;
    dec       = 1'b0;
    perdido_d = 1'b0;
    case (estado_q)
      estirador_pkg::REPOSO: begin
        if (iDisparo) begin
          estado_d = estirador_pkg::ACTIVO;
          carga    = 1'b1;
        end
      end
      estirador_pkg::ACTIVO: begin
        // Counter reads N in the first high cycle and 1 in the last; the exit
        // decrement leaves it at 0 while idle.
        dec = 1'b1;
        if (ultimo || cero) begin
          estado_d = estirador_pkg::GUARDA;
          guarda_d = GUARDA_CARGA;
        end
        if (iDisparo) begin
`ifdef ESTIRADOR_REDISPARO_EN
          carga    = 1'b1;
          estado_d = estirador_pkg::ACTIVO;
          guarda_d = '0;
`else
          perdido_d = 1'b1;
`endif
        end
      end
      estirador_pkg::GUARDA: begin
        perdido_d = iDisparo;
        if (guarda_q <= GCNT_W'(1)) begin
          estado_d = estirador_pkg::REPOSO;
          guarda_d = '0;
        end else begin
          guarda_d = guarda_q - 1'b1;
        end
      end
      default: begin
        estado_d = estirador_pkg::REPOSO;
        guarda_d = '0;
      end
    endcase
    senal_d   = (estado_d == estirador_pkg::ACTIVO);
    ocupado_d = (estado_d != estirador_pkg::REPOSO);
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      estado_q  <= estirador_pkg::REPOSO;
      guarda_q  <= '0;
      senal_q   <= 1'b0;
      ocupado_q <= 1'b0;
      perdido_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      guarda_q  <= guarda_d;
      senal_q   <= senal_d;
      ocupado_q <= ocupado_d;
      perdido_q <= perdido_d;
    end
  end

  assign oSenal   = senal_q;
  assign oOcupado = ocupado_q;
  assign oPerdido = perdido_q;

endmodule

// File: tb/tb_estirador_pulsos.sv
// Directed bench for estirador_pulsos (CNT_W=8, GUARDA=2); follows ESTIRADOR_REDISPARO_EN if defined.
module tb_estirador_pulsos;

  logic       iClk = 1'b0;
  logic       iReset = 1'b0;
  logic       iDisparo = 1'b0;
  logic [7:0] iAncho = '0;
  logic       oSenal, oOcupado, oPerdido;

  int checks = 0;
  int errors = 0;
  int n;

  estirador_pulsos #(
    .CNT_W  (8),
    .GUARDA (2)
  ) dut (
    .iClk     (iClk),
    .iReset   (iReset),
    .iDisparo (iDisparo),
    .iAncho   (iAncho),
    .oSenal   (oSenal),
    .oOcupado (oOcupado),
    .oPerdido (oPerdido)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present inputs for one edge, then land 1 time unit into the following cycle.
  task automatic paso(input logic d, input logic [7:0] a);
    iDisparo = d;
    iAncho   = a;
    @(posedge iClk);
    #1;
    iDisparo = 1'b0;
  endtask

  task automatic contar_alto(output int cnt);
    cnt = 0;
    while (oSenal === 1'b1 && cnt < 400) begin
      cnt++;
      paso(1'b0, 8'd0);
    end
  endtask

  task automatic contar_guarda(output int cnt);
    cnt = 0;
    while (oOcupado === 1'b1 && oSenal === 1'b0 && cnt < 20) begin
      cnt++;
      paso(1'b0, 8'd0);
    end
  endtask

  initial begin
    #2 iReset = 1'b1;
    #1;
    chk("rst_senal", oSenal, 0);
    chk("rst_ocupado", oOcupado, 0);
    chk("rst_perdido", oPerdido, 0);
    @(posedge iClk);
    #1 iReset = 1'b0;

    // Basic pulse: 5 high, 2 guard, then re-trigger in first idle cycle
    repeat (3) paso(1'b0, 8'd0);
    paso(1'b1, 8'd5);
    chk("a_senal_c1", oSenal, 1);
    chk("a_ocupado_c1", oOcupado, 1);
    chk("a_perdido_c1", oPerdido, 0);
    for (int i = 2; i <= 5; i++) begin
      paso(1'b0, 8'd0);
      chk("a_senal_alto", oSenal, 1);
    end
    paso(1'b0, 8'd0);
    chk("a_guarda1_senal", oSenal, 0);
    chk("a_guarda1_ocupado", oOcupado, 1);
    paso(1'b0, 8'd0);
    chk("a_guarda2_senal", oSenal, 0);
    chk("a_guarda2_ocupado", oOcupado, 1);
    paso(1'b0, 8'd0);
    chk("a_reposo_ocupado", oOcupado, 0);
    paso(1'b1, 8'd5);
    chk("a_redisparo_senal", oSenal, 1);
    chk("a_redisparo_perdido", oPerdido, 0);
    contar_alto(n);
    chk("a_largo", n, 5);
    contar_guarda(n);
    chk("a_guarda_largo", n, 2);

    // Trigger in the last guard cycle is lost, next cycle's trigger is taken
    paso(1'b1, 8'd2);
    repeat (3) paso(1'b0, 8'd0);
    chk("g_ultimo_ocupado", oOcupado, 1);
    chk("g_ultimo_senal", oSenal, 0);
    paso(1'b1, 8'd7);
    chk("g_rechazo_perdido", oPerdido, 1);
    chk("g_rechazo_ocupado", oOcupado, 0);
    paso(1'b1, 8'd3);
    chk("g_acepta_perdido", oPerdido, 0);
    chk("g_acepta_senal", oSenal, 1);
    contar_alto(n);
    chk("g_largo", n, 3);
    contar_guarda(n);
    chk("g_guarda_largo", n, 2);

    // Width boundaries
    paso(1'b1, 8'd0);
    contar_alto(n);
    chk("ancho0_largo", n, 1);
    contar_guarda(n);
    chk("ancho0_guarda", n, 2);
    paso(1'b1, 8'd255);
    contar_alto(n);
    chk("ancho255_largo", n, 255);
    contar_guarda(n);
    chk("ancho255_guarda", n, 2);

`ifdef ESTIRADOR_REDISPARO_EN
    // Retrigger at edge 3 extends pulse to cycles 1..6; trigger in guard is lost
    paso(1'b1, 8'd4);
    paso(1'b0, 8'd0);
    paso(1'b0, 8'd0);
    chk("r_c3_senal", oSenal, 1);
    paso(1'b1, 8'd3);
    chk("r_c4_senal", oSenal, 1);
    chk("r_c4_perdido", oPerdido, 0);
    contar_alto(n);
    chk("r_largo_tras_recarga", n, 3);
    paso(1'b1, 8'd5);
    chk("r_guarda_perdido", oPerdido, 1);
    chk("r_guarda_senal", oSenal, 0);
    chk("r_guarda_ocupado", oOcupado, 1);
    paso(1'b0, 8'd0);
    chk("r_fin_ocupado", oOcupado, 0);
    chk("r_fin_perdido", oPerdido, 0);
`else
    // Trigger at edge 2 is rejected; pulse stays cycles 1..4
    paso(1'b1, 8'd4);
    chk("r_c1_senal", oSenal, 1);
    paso(1'b0, 8'd0);
    paso(1'b1, 8'd9);
    chk("r_c3_senal", oSenal, 1);
    chk("r_c3_perdido", oPerdido, 1);
    paso(1'b0, 8'd0);
    chk("r_c4_senal", oSenal, 1);
    chk("r_c4_perdido", oPerdido, 0);
    paso(1'b0, 8'd0);
    chk("r_c5_senal", oSenal, 0);
    chk("r_c5_ocupado", oOcupado, 1);
    contar_guarda(n);
    chk("r_guarda_largo", n, 2);
`endif

    // Back-to-back triggers from idle
    paso(1'b1, 8'd2);
    paso(1'b1, 8'd2);
    chk("b2b_senal", oSenal, 1);
`ifdef ESTIRADOR_REDISPARO_EN
    chk("b2b_perdido", oPerdido, 0);
    contar_alto(n);
    chk("b2b_largo", n, 2);
`else
    chk("b2b_perdido", oPerdido, 1);
    contar_alto(n);
    chk("b2b_largo", n, 1);
`endif
    contar_guarda(n);
    chk("b2b_guarda", n, 2);

    // Reset in the middle of cycle 4 clears outputs before the next edge
    paso(1'b1, 8'd10);
    paso(1'b0, 8'd0);
    paso(1'b0, 8'd0);
`ifdef ESTIRADOR_REDISPARO_EN
    paso(1'b0, 8'd0);
`else
    paso(1'b1, 8'd9);
    chk("rm_perdido_previo", oPerdido, 1);
`endif
    chk("rm_senal_previo", oSenal, 1);
    #2 iReset = 1'b1;
    #1;
    chk("rm_senal", oSenal, 0);
    chk("rm_ocupado", oOcupado, 0);
    chk("rm_perdido", oPerdido, 0);
    @(posedge iClk);
    #1 iReset = 1'b0;
    paso(1'b1, 8'd10);
    chk("rm_nuevo_ocupado", oOcupado, 1);
    contar_alto(n);
    chk("rm_nuevo_largo", n, 10);
    contar_guarda(n);
    chk("rm_nuevo_guarda", n, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/estirador_pulsos.md
ESTIRADOR_PULSOS -- requirements
Module: estirador_pulsos

Interface
REQ-001 The block SHALL take parameter CNT_W, default 8, as the width of the pulse-length counter and of iAncho.
REQ-002 The block SHALL take parameter GUARDA, default 2, as the number of forced-low cycles after each output pulse; the legal range SHALL be 1..15.
REQ-003 iClk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 iReset  input  1  asynchronous, active-high reset.
REQ-005 iDisparo  input  1  single-cycle trigger; a cycle with iDisparo=1 SHALL be one trigger request.
REQ-006 iAncho  input  CNT_W  requested high time in iClk cycles; it SHALL be sampled only in the cycle a trigger is accepted.
REQ-007 oSenal  output  1  registered level output, high for the stretched pulse.
REQ-008 oOcupado  output  1  registered flag, high while the state is ACTIVO or GUARDA.
REQ-009 oPerdido  output  1  registered one-cycle flag marking a trigger that was rejected.

Function
REQ-010 The FSM SHALL have exactly three states: REPOSO, ACTIVO and GUARDA.
REQ-011 In REPOSO, iDisparo=1 at rising edge k SHALL cause three things:
- a move to ACTIVO;
- loading of the counter with N = max(iAncho,1);
- oSenal=1 from edge k+1.
REQ-012 oSenal SHALL stay high for exactly N consecutive cycles.
- iAncho=0 SHALL be treated as 1.
- iAncho=2^CNT_W-1 SHALL give 2^CNT_W-1 cycles with no wrap-around.
REQ-013 At the end of the last ACTIVO cycle, the FSM SHALL enter GUARDA with oSenal=0 and hold it low for exactly GUARDA cycles, then return to REPOSO.
REQ-014 When a trigger arrives in the last GUARDA cycle, it SHALL be rejected. A trigger arriving in the first REPOSO cycle after that SHALL be accepted.
REQ-015 The minimum low time between two output pulses SHALL be GUARDA cycles, so that a downstream two-flip-flop rising-edge detector sees every pulse.
REQ-016 A rejected trigger at edge k SHALL make oPerdido=1 during cycle k+1 only.
REQ-017 oOcupado SHALL be 1 in exactly the cycles where the state is ACTIVO or GUARDA.
REQ-018 Back-to-back triggers in consecutive cycles from REPOSO: the first SHALL be accepted and the second handled per REQ-023 or REQ-024.
REQ-019 The counter SHALL be CNT_W bits wide and decrement by 1 per ACTIVO cycle. It SHALL never underflow. The GUARDA counter SHALL be 4 bits wide.

Reset
REQ-020 iReset=1 SHALL force, immediately and independent of iClk:
- state REPOSO;
- counters 0;
- oSenal=0, oOcupado=0, oPerdido=0.
REQ-021 Reset asserted mid-pulse SHALL truncate the pulse immediately. No GUARDA period SHALL follow.
REQ-022 In the first rising edge after iReset deasserts, a trigger SHALL be accepted normally.

Configuration
REQ-023 With macro ESTIRADOR_REDISPARO_EN defined:
- a trigger in ACTIVO SHALL reload the counter with max(iAncho,1) and keep oSenal high continuously, so the new pulse length counts from the next edge;
- this SHALL include a trigger in the last ACTIVO cycle;
- the trigger SHALL not assert oPerdido;
- a trigger in GUARDA SHALL be rejected.
REQ-024 With macro ESTIRADOR_REDISPARO_EN undefined, every trigger in ACTIVO or GUARDA SHALL be rejected, and the counter SHALL be unaffected.

Structure
REQ-025 A shared package estirador_pkg SHALL hold the following:
- the state encoding (REPOSO=2'd0, ACTIVO=2'd1, GUARDA=2'd2);
- default constants CNT_W_DEF=8 and GUARDA_DEF=2.
REQ-026 One sub-module, contador_descendente, SHALL be instantiated. It provides loadable down-count with a zero flag, is parameterized by width, and is used for the pulse counter.
REQ-027 The GUARDA counter and the FSM SHALL stay in estirador_pulsos.

Verification
REQ-028 The bench SHALL cover these directed scenarios (CNT_W=8, GUARDA=2):
- Reset, then a trigger with iAncho=5 at edge 10 -> oSenal=1 in cycles 11..15 and 0 in cycles 16..17. oOcupado=1 in cycles 11..17. Trigger at edge 18 is accepted.
- Trigger with iAncho=0 -> oSenal high exactly 1 cycle. Trigger with iAncho=255 -> high exactly 255 cycles.
- Macro undefined; iAncho=4 trigger at edge 0, second trigger at edge 2 -> pulse in cycles 1..4 only, oPerdido=1 in cycle 3.
- Macro defined; iAncho=4 at edge 0, iAncho=3 at edge 3 -> oSenal continuously high in cycles 1..6, oPerdido stays 0. A trigger during GUARDA -> oPerdido pulse.
- iAncho=10 trigger, then iReset asserted mid-cycle 4 -> oSenal, oOcupado and oPerdido fall to 0 before the next edge. Trigger right after release starts a fresh 10-cycle pulse.
